phase_seq: RTL
==============

Name: phase_seq

Overview:
- Parametrised phase controller for the single-pass GF(x) systemizer.
- Sequences an external step engine over a programmable column-block window [start_block, end_block] instead of a fixed run to K/N-1.
- Drives col_block, first_pass_rows and functionA to the step engine.
- Adds a per-step watchdog, an abort input, a config check, sticky fail, a busy flag and a step-progress counter.

Parameters:
- N, 4, column-block width in matrix columns
- L, 8, matrix row count
- K, 16, matrix column count; K/N blocks, K divisible by N
- TIMEOUT, 0, maximum cycles from step_start to step_done; 0 disables the watchdog
- BW, CLOG2(K/N+1), block-index width, derived
- RW, CLOG2(L*K/N+2*N+1), first_pass_rows width, derived
- TW, CLOG2(TIMEOUT+2), watchdog counter width, derived

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  launch request pulse
- abort  in  1  cancel current phase
- start_block  in  BW  first column block
- end_block  in  BW  last column block, inclusive
- busy  out  1  phase in progress
- done  out  1  one-cycle pulse, phase completed
- fail  out  1  sticky failure level
- step_start  out  1  one-cycle pulse, launch step engine
- step_done  in  1  step engine completion pulse
- step_fail  in  1  step engine failure, sampled with step_done
- col_block  out  BW  block under processing
- first_pass_rows  out  RW  L*start_block + L - N*start_block
- functionA  out  1  high from accept until the first step_done
- steps_done  out  BW  completed steps in current phase

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0, watchdog counter 0.
- States: IDLE, WAIT.
- IDLE:
  - start=1 with start_block<=end_block<K/N is accepted.
  - Next edge: state=WAIT, busy=1, col_block=start_block, first_pass_rows computed (latched until next accept), functionA=1, fail=0, steps_done=0, step_start=1 for exactly one cycle.
  - start=1 with an invalid window: next edge fail=1, busy stays 0, no step_start.
  - step_done/step_fail in IDLE are ignored.
- WAIT, on step_done=1:
  - steps_done increments and functionA clears.
  - If step_fail=1: fail=1, state=IDLE, done stays 0.
  - Else if col_block==end_block: done=1 for one cycle, state=IDLE, col_block and steps_done hold their final values.
  - Else: col_block+1, and step_start pulses on the following cycle.
- Latency: step_done at edge t gives step_start or done at edge t+1. No gap cycles between steps.
- Watchdog, only when TIMEOUT>0:
  - The counter clears on each step_start and counts while WAIT and !step_done.
  - When it reaches TIMEOUT without step_done: fail=1, state=IDLE. The counter saturates and never wraps.
- abort=1 in WAIT: state=IDLE, busy=0, done=0, fail unchanged. Abort wins over a simultaneous step_done or timeout.
- start while busy is ignored. start and abort in the same cycle in IDLE: abort wins and start is ignored.
- fail holds until the next accepted start, or rst.
- Arithmetic: first_pass_rows is computed at RW width with no overflow, guaranteed by the RW sizing. col_block never exceeds end_block.

Test Plan:
- N=4,L=8,K=16, start_block=0,end_block=3, step_done 5 cycles after each step_start -> 4 step_start pulses, col_block 0,1,2,3, first_pass_rows=8, functionA low after first step_done, done pulse 1 cycle after the 4th step_done, steps_done=4, fail=0.
- start_block=1,end_block=2 -> first_pass_rows=12, exactly 2 steps (col_block 1,2), done asserted, busy low the cycle after done.
- TIMEOUT=16, step_done never returned -> fail=1 exactly 16 cycles after step_start, busy=0, no done. The next valid start clears fail.
- step_done with step_fail=1 on the 2nd step of a 0..3 run -> fail=1, steps_done=2, no further step_start.
- abort asserted in the same cycle as the 3rd step_done -> busy=0, no step_start, no done, fail=0. A start while busy earlier in the run has no effect.
- start_block=3,end_block=2 -> fail=1, busy never rises. rst pulled low mid-run -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/phase_seq_if.sv
// Bundle of the phase-control side and the step-engine side of phase_seq.
// The master modport is the sequencer; the slave modport is its environment.
interface phase_seq_if #(
  parameter int N = 4,
  parameter int L = 8,
  parameter int K = 16
) ();
  localparam int BW = $clog2(K / N + 1);
  localparam int RW = $clog2(L * K / N + 2 * N + 1);

  logic          start;
  logic          abort;
  logic [BW-1:0] start_block;
  logic [BW-1:0] end_block;
  logic          busy;
  logic          done;
  logic          fail;
  logic [BW-1:0] steps_done;

  logic          step_start;
  logic          step_done;
  logic          step_fail;
  logic [BW-1:0] col_block;
  logic [RW-1:0] first_pass_rows;
  logic          functionA;

  modport master (
    input  start, abort, start_block, end_block, step_done, step_fail,
    output busy, done, fail, steps_done, step_start, col_block,
           first_pass_rows, functionA
  );

  modport slave (
    output start, abort, start_block, end_block, step_done, step_fail,
    input  busy, done, fail, steps_done, step_start, col_block,
           first_pass_rows, functionA
  );
endinterface

// File: rtl/phase_seq.sv
// Phase controller for the single-pass GF(x) systemizer: walks the step engine
// over the column-block window [start_block, end_block] with a per-step watchdog.
module phase_seq #(
  parameter int N       = 4,
  parameter int L       = 8,
  parameter int K       = 16,
  parameter int TIMEOUT = 0
) (
  input  logic           clk,
  input  logic           rst,
  phase_seq_if.master    bus
);
  localparam int BW = $clog2(K / N + 1);
  localparam int RW = $clog2(L * K / N + 2 * N + 1);
  localparam int TW = $clog2(TIMEOUT + 2);

  localparam logic [BW-1:0] NBLK    = BW'(K / N);
  localparam logic [RW-1:0] L_RW    = RW'(L);
  localparam logic [RW-1:0] N_RW    = RW'(N);
  localparam logic [TW-1:0] WD_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] WD_MAX  = TW'(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] col_q, col_d;
  logic [BW-1:0] end_q, end_d;
  logic [BW-1:0] steps_q, steps_d;
  logic [RW-1:0] fpr_q, fpr_d;
  logic          fa_q, fa_d;
  logic          fail_q, fail_d;
  logic          done_q, done_d;
  logic          sstart_q, sstart_d;
  logic [TW-1:0] wd_q, wd_d;

  logic          window_ok;
  logic [RW-1:0] fpr_calc;

  assign window_ok = (bus.start_block <= bus.end_block) && (bus.end_block < NBLK);
  // L*sb + L never falls below N*sb for a legal window, so the subtraction stays positive.
  assign fpr_calc  = L_RW * RW'(bus.start_block) + L_RW - N_RW * RW'(bus.start_block);

  // NOTE: every next-state value gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    end_d    = end_q;
    steps_d  = steps_q;
    fpr_d    = fpr_q;
    fa_d     = fa_q;
    fail_d   = fail_q;
    wd_d     = wd_q;
    done_d   = 1'b0;
    sstart_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (window_ok) begin
            state_d  = WAIT;
            col_d    = bus.start_block;
            end_d    = bus.end_block;
            steps_d  = '0;
            fpr_d    = fpr_calc;
            fa_d     = 1'b1;
            fail_d   = 1'b0;
            sstart_d = 1'b1;
            wd_d     = '0;
          end else begin
            fail_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.step_done) begin
          steps_d = steps_q + BW'(1);
          fa_d    = 1'b0;
          if (bus.step_fail) begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end else if (col_q == end_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            col_d    = col_q + BW'(1);
            sstart_d = 1'b1;
            wd_d     = '0;
          end
        end else if (TIMEOUT > 0) begin
          // The counter parks at TIMEOUT once it fires and never wraps.
          if (wd_q >= WD_LAST) begin
            wd_d    = WD_MAX;
            fail_d  = 1'b1;
            state_d = IDLE;
          end else begin
            wd_d = wd_q + TW'(1);
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      col_q    <= '0;
      end_q    <= '0;
      steps_q  <= '0;
      fpr_q    <= '0;
      fa_q     <= 1'b0;
      fail_q   <= 1'b0;
      done_q   <= 1'b0;
      sstart_q <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      end_q    <= end_d;
      steps_q  <= steps_d;
      fpr_q    <= fpr_d;
      fa_q     <= fa_d;
      fail_q   <= fail_d;
      done_q   <= done_d;
      sstart_q <= sstart_d;
      wd_q     <= wd_d;
    end
  end

  assign bus.busy            = (state_q == WAIT);
  assign bus.done            = done_q;
  assign bus.fail            = fail_q;
  assign bus.steps_done      = steps_q;
  assign bus.step_start      = sstart_q;
  assign bus.col_block       = col_q;
  assign bus.first_pass_rows = fpr_q;
  assign bus.functionA       = fa_q;
endmodule
